// File: rtl/ifm_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ifm_scan_ctrl
//   Sequencer for IFM_BUF. Walks a 3x3 window over an IFM_H x IFM_W feature map
//   in snake order: right along even window-rows, left along odd window-rows,
//   one DOWN step between rows. Every step goes through a three-stage pipeline:
//     S0 : feature-map read request (rd_en / rd_cmd / rd_row / rd_col)
//     S1 : IFM_BUF move code (ifm_read), aligned with the returned read data
//     S2 : window presented to the PE array (win_valid / win_row / win_col / win_last)
//
//   Handshake: a window is transferred on a cycle where win_valid && win_ready.
//   The whole pipeline advances together when adv = !win_valid || win_ready.
//   If adv is low, every stage holds its contents, no read is issued (rd_en=0),
//   and IFM_BUF is told to hold its contents (ifm_read=KEEP). The memory must
//   keep its dout stable while rd_en is low.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a scan (sampled only when idle)
//   rd_en/rd_cmd/rd_row/rd_col   read request and move code for the new window
//   ifm_read            IFM_BUF code: ALL=000 RIGHT=001 DOWN=010 LEFT=100 KEEP=111
//   win_valid/win_ready handshake with the PE array
//   win_row/win_col     top-left corner of the presented window
//   win_last            presented window is the final one
//   busy                scan in progress
//   done                one-cycle pulse after the final window is accepted
// ---------------------------------------------------------------------------
module ifm_scan_ctrl #(
  parameter int IFM_W = 8,
  parameter int IFM_H = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             rd_en,
  output logic [2:0]       rd_cmd,
  output logic [CNT_W-1:0] rd_row,
  output logic [CNT_W-1:0] rd_col,
  output logic [2:0]       ifm_read,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [CNT_W-1:0] win_row,
  output logic [CNT_W-1:0] win_col,
  output logic             win_last,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] CMD_ALL   = 3'b000;
  localparam logic [2:0] CMD_RIGHT = 3'b001;
  localparam logic [2:0] CMD_DOWN  = 3'b010;
  localparam logic [2:0] CMD_LEFT  = 3'b100;
  localparam logic [2:0] CMD_KEEP  = 3'b111;

  // Last legal top-left coordinates of a 3x3 window.
  localparam logic [CNT_W-1:0] COL_END = CNT_W'(IFM_W - 3);
  localparam logic [CNT_W-1:0] ROW_END = CNT_W'(IFM_H - 3);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // S0: move currently being requested from memory, plus scan direction.
  logic             s0_valid_q, s0_valid_d;
  logic [2:0]       s0_cmd_q,   s0_cmd_d;
  logic [CNT_W-1:0] s0_row_q,   s0_row_d;
  logic [CNT_W-1:0] s0_col_q,   s0_col_d;
  logic             dir_left_q, dir_left_d;

  // S1: move whose read data is arriving this cycle.
  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_cmd_q,   s1_cmd_d;
  logic [CNT_W-1:0] s1_row_q,   s1_row_d;
  logic [CNT_W-1:0] s1_col_q,   s1_col_d;
  logic             s1_last_q,  s1_last_d;

  // S2: window held in IFM_BUF and presented to the PE array.
  logic             win_valid_q, win_valid_d;
  logic [CNT_W-1:0] win_row_q,   win_row_d;
  logic [CNT_W-1:0] win_col_q,   win_col_d;
  logic             win_last_q,  win_last_d;

  logic adv;
  logic run;

  // Successor of the move held in S0. nxt_has=0 means S0 holds the final move.
  logic             nxt_has;
  logic [2:0]       nxt_cmd;
  logic [CNT_W-1:0] nxt_row;
  logic [CNT_W-1:0] nxt_col;
  logic             nxt_dir_left;

  always_comb begin
    nxt_has      = 1'b0;
    nxt_cmd      = s0_cmd_q;
    nxt_row      = s0_row_q;
    nxt_col      = s0_col_q;
    nxt_dir_left = dir_left_q;
    if (!dir_left_q) begin
      if (s0_col_q < COL_END) begin
        nxt_has = 1'b1;
        nxt_cmd = CMD_RIGHT;
        nxt_col = s0_col_q + 1'b1;
      end else if (s0_row_q < ROW_END) begin
        nxt_has      = 1'b1;
        nxt_cmd      = CMD_DOWN;
        nxt_row      = s0_row_q + 1'b1;
        nxt_dir_left = 1'b1;
      end
    end else begin
      if (s0_col_q != '0) begin
        nxt_has = 1'b1;
        nxt_cmd = CMD_LEFT;
        nxt_col = s0_col_q - 1'b1;
      end else if (s0_row_q < ROW_END) begin
        nxt_has      = 1'b1;
        nxt_cmd      = CMD_DOWN;
        nxt_row      = s0_row_q + 1'b1;
        nxt_dir_left = 1'b0;
      end
    end
  end

  assign run = (state_q == ST_RUN);
  assign adv = !win_valid_q || win_ready;

  always_comb begin
    state_d     = state_q;
    s0_valid_d  = s0_valid_q;
    s0_cmd_d    = s0_cmd_q;
    s0_row_d    = s0_row_q;
    s0_col_d    = s0_col_q;
    dir_left_d  = dir_left_q;
    s1_valid_d  = s1_valid_q;
    s1_cmd_d    = s1_cmd_q;
    s1_row_d    = s1_row_q;
    s1_col_d    = s1_col_q;
    s1_last_d   = s1_last_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_last_d  = win_last_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          s0_valid_d = 1'b1;
          s0_cmd_d   = CMD_ALL;
          s0_row_d   = '0;
          s0_col_d   = '0;
          dir_left_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (adv) begin
          // S1 -> S2
          win_valid_d = s1_valid_q;
          win_row_d   = s1_row_q;
          win_col_d   = s1_col_q;
          win_last_d  = s1_last_q;
          // S0 -> S1; the last flag is known once S0 has no successor.
          s1_valid_d  = s0_valid_q;
          s1_cmd_d    = s0_cmd_q;
          s1_row_d    = s0_row_q;
          s1_col_d    = s0_col_q;
          s1_last_d   = !nxt_has;
          // Generate the next move into S0 (bubbles once the walk has ended).
          if (s0_valid_q) begin
            s0_valid_d = nxt_has;
            if (nxt_has) begin
              s0_cmd_d   = nxt_cmd;
              s0_row_d   = nxt_row;
              s0_col_d   = nxt_col;
              dir_left_d = nxt_dir_left;
            end
          end
        end
        if (win_valid_q && win_ready && win_last_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s0_valid_q  <= 1'b0;
      s0_cmd_q    <= CMD_ALL;
      s0_row_q    <= '0;
      s0_col_q    <= '0;
      dir_left_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_cmd_q    <= CMD_ALL;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      s1_last_q   <= 1'b0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      s0_valid_q  <= s0_valid_d;
      s0_cmd_q    <= s0_cmd_d;
      s0_row_q    <= s0_row_d;
      s0_col_q    <= s0_col_d;
      dir_left_q  <= dir_left_d;
      s1_valid_q  <= s1_valid_d;
      s1_cmd_q    <= s1_cmd_d;
      s1_row_q    <= s1_row_d;
      s1_col_q    <= s1_col_d;
      s1_last_q   <= s1_last_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_last_q  <= win_last_d;
    end
  end

  // A read is only issued on a cycle where S0 actually moves into S1.
  assign rd_en    = run && s0_valid_q && adv;
  assign rd_cmd   = s0_cmd_q;
  assign rd_row   = s0_row_q;
  assign rd_col   = s0_col_q;
  // KEEP on stalls and on bubbles so IFM_BUF never shifts without new data.
  assign ifm_read = (run && adv && s1_valid_q) ? s1_cmd_q : CMD_KEEP;

  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign win_last  = win_last_q;
  assign busy      = run;
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_ifm_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ifm_scan_ctrl
//   Three DUT instances (8x8, 3x3, 3x6) share clock and reset. A reference
//   model builds the expected read, move-code and window sequences from the
//   snake walk directly; the bench pops them as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_ifm_scan_ctrl;

  localparam logic [2:0] C_ALL   = 3'b000;
  localparam logic [2:0] C_RIGHT = 3'b001;
  localparam logic [2:0] C_DOWN  = 3'b010;
  localparam logic [2:0] C_LEFT  = 3'b100;
  localparam logic [2:0] C_KEEP  = 3'b111;

  int ifm_w_t[3] = '{8, 3, 3};
  int ifm_h_t[3] = '{8, 3, 6};

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       start_s[3];
  logic       win_ready_s[3];
  logic       rd_en_s[3];
  logic [2:0] rd_cmd_s[3];
  logic [7:0] rd_row_s[3];
  logic [7:0] rd_col_s[3];
  logic [2:0] ifm_read_s[3];
  logic       win_valid_s[3];
  logic [7:0] win_row_s[3];
  logic [7:0] win_col_s[3];
  logic       win_last_s[3];
  logic       busy_s[3];
  logic       done_s[3];

  ifm_scan_ctrl #(.IFM_W(8), .IFM_H(8), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]),
    .rd_en(rd_en_s[0]), .rd_cmd(rd_cmd_s[0]), .rd_row(rd_row_s[0]), .rd_col(rd_col_s[0]),
    .ifm_read(ifm_read_s[0]), .win_valid(win_valid_s[0]), .win_ready(win_ready_s[0]),
    .win_row(win_row_s[0]), .win_col(win_col_s[0]), .win_last(win_last_s[0]),
    .busy(busy_s[0]), .done(done_s[0])
  );

  ifm_scan_ctrl #(.IFM_W(3), .IFM_H(3), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]),
    .rd_en(rd_en_s[1]), .rd_cmd(rd_cmd_s[1]), .rd_row(rd_row_s[1]), .rd_col(rd_col_s[1]),
    .ifm_read(ifm_read_s[1]), .win_valid(win_valid_s[1]), .win_ready(win_ready_s[1]),
    .win_row(win_row_s[1]), .win_col(win_col_s[1]), .win_last(win_last_s[1]),
    .busy(busy_s[1]), .done(done_s[1])
  );

  ifm_scan_ctrl #(.IFM_W(3), .IFM_H(6), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]),
    .rd_en(rd_en_s[2]), .rd_cmd(rd_cmd_s[2]), .rd_row(rd_row_s[2]), .rd_col(rd_col_s[2]),
    .ifm_read(ifm_read_s[2]), .win_valid(win_valid_s[2]), .win_ready(win_ready_s[2]),
    .win_row(win_row_s[2]), .win_col(win_col_s[2]), .win_last(win_last_s[2]),
    .busy(busy_s[2]), .done(done_s[2])
  );

  // scoreboard
  logic [18:0] exp_rd_q[$];    // {cmd, row, col}
  logic [2:0]  exp_code_q[$];  // ifm_read codes
  logic [16:0] exp_win_q[$];   // {row, col, last}

  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: enumerate the snake walk and derive each move code from
  // how the window corner changed relative to the previous window.
  task automatic build_model(input int k);
    int w, h, n, idx, pr, pc, c;
    logic [2:0] cmd;
    w = ifm_w_t[k];
    h = ifm_h_t[k];
    n = (w - 2) * (h - 2);
    exp_rd_q.delete();
    exp_code_q.delete();
    exp_win_q.delete();
    idx = 0;
    pr = 0;
    pc = 0;
    for (int r = 0; r <= h - 3; r++) begin
      for (int j = 0; j <= w - 3; j++) begin
        c = (r % 2 == 0) ? j : (w - 3 - j);
        if (idx == 0)     cmd = C_ALL;
        else if (r != pr) cmd = C_DOWN;
        else if (c > pc)  cmd = C_RIGHT;
        else              cmd = C_LEFT;
        exp_rd_q.push_back({cmd, 8'(r), 8'(c)});
        exp_code_q.push_back(cmd);
        exp_win_q.push_back({8'(r), 8'(c), 1'(idx == n - 1)});
        pr = r;
        pc = c;
        idx++;
      end
    end
  endtask

  task automatic check_reset_vals(input int k, input string pfx);
    chk({pfx, "_rd_en"},     rd_en_s[k],     0);
    chk({pfx, "_rd_cmd"},    rd_cmd_s[k],    C_ALL);
    chk({pfx, "_rd_row"},    rd_row_s[k],    0);
    chk({pfx, "_rd_col"},    rd_col_s[k],    0);
    chk({pfx, "_ifm_read"},  ifm_read_s[k],  C_KEEP);
    chk({pfx, "_win_valid"}, win_valid_s[k], 0);
    chk({pfx, "_win_row"},   win_row_s[k],   0);
    chk({pfx, "_win_col"},   win_col_s[k],   0);
    chk({pfx, "_win_last"},  win_last_s[k],  0);
    chk({pfx, "_busy"},      busy_s[k],      0);
    chk({pfx, "_done"},      done_s[k],      0);
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return cyc[0];
    return ($urandom_range(0, 3) != 0);
  endfunction

  // driver: one scan on instance k.
  //   mode 0: win_ready=1, 1: toggling, 2: random
  //   pulse_at: cycle with an extra start pulse (-1 none)
  //   reset_at: cycle at which rst_n is asserted (-1 none)
  task automatic run_scan(input int k, input int mode, input int pulse_at, input int reset_at);
    int n, cyc, acc_cyc, first_rd, first_code, first_win;
    bit fin, aborted;
    logic [18:0] e_rd;
    logic [2:0]  e_code;
    logic [16:0] e_win;
    build_model(k);
    n = exp_win_q.size();
    @(negedge clk);
    start_s[k] = 1'b1;
    win_ready_s[k] = pick_ready(mode, 0);
    cyc = 0;
    acc_cyc = -1;
    first_rd = -1;
    first_code = -1;
    first_win = -1;
    fin = 0;
    aborted = 0;
    while (!fin && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      #1;
      start_s[k] = (cyc == pulse_at);
      win_ready_s[k] = pick_ready(mode, cyc);
      if (cyc == reset_at) begin
        start_s[k] = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_vals(k, "abort");
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_done", done_s[k], 0);
        chk("abort_busy", busy_s[k], 0);
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
        fin = 1;
      end else begin
        @(negedge clk);
        chk("busy", busy_s[k], (acc_cyc < 0));
        chk("done", done_s[k], (acc_cyc >= 0 && cyc == acc_cyc + 1));
        if (win_valid_s[k] && !win_ready_s[k]) begin
          chk("stall_ifm_read", ifm_read_s[k], C_KEEP);
          chk("stall_rd_en", rd_en_s[k], 0);
        end
        if (rd_en_s[k]) begin
          if (first_rd < 0) first_rd = cyc;
          chk("rd_avail", (exp_rd_q.size() > 0), 1);
          if (exp_rd_q.size() > 0) begin
            e_rd = exp_rd_q.pop_front();
            chk("rd_cmd", rd_cmd_s[k], e_rd[18:16]);
            chk("rd_row", rd_row_s[k], e_rd[15:8]);
            chk("rd_col", rd_col_s[k], e_rd[7:0]);
          end
        end
        if (ifm_read_s[k] != C_KEEP) begin
          if (first_code < 0) first_code = cyc;
          chk("code_avail", (exp_code_q.size() > 0), 1);
          if (exp_code_q.size() > 0) begin
            e_code = exp_code_q.pop_front();
            chk("ifm_read", ifm_read_s[k], e_code);
          end
        end
        if (win_valid_s[k] && win_ready_s[k]) begin
          if (first_win < 0) first_win = cyc;
          chk("win_avail", (exp_win_q.size() > 0), 1);
          if (exp_win_q.size() > 0) begin
            e_win = exp_win_q.pop_front();
            chk("win_row", win_row_s[k], e_win[16:9]);
            chk("win_col", win_col_s[k], e_win[8:1]);
            chk("win_last", win_last_s[k], e_win[0]);
            if (e_win[0]) acc_cyc = cyc;
          end
        end
        if (done_s[k]) fin = 1;
      end
    end
    start_s[k] = 1'b0;
    win_ready_s[k] = 1'b0;
    chk("scan_terminated", fin, 1);
    if (!aborted) begin
      chk("rd_left", exp_rd_q.size(), 0);
      chk("code_left", exp_code_q.size(), 0);
      chk("win_left", exp_win_q.size(), 0);
      if (mode == 0) begin
        chk("first_rd_cycle", first_rd, 1);
        chk("first_code_cycle", first_code, 2);
        chk("first_win_cycle", first_win, 3);
        chk("last_win_cycle", acc_cyc, n + 2);
        chk("done_cycle", cyc, n + 3);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      win_ready_s[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals(0, "reset0");
    check_reset_vals(1, "reset1");
    check_reset_vals(2, "reset2");
    @(negedge clk);
    rst_n = 1'b1;

    run_scan(0, 0, -1, -1);   // 8x8 full rate
    run_scan(0, 1, -1, -1);   // 8x8 toggling ready
    run_scan(1, 0, -1, -1);   // 3x3 single window
    run_scan(2, 0, -1, -1);   // 3x6 ALL + DOWNs
    run_scan(2, 2, -1, -1);
    run_scan(0, 2, -1, 10);   // reset mid-scan
    run_scan(0, 0, -1, -1);   // restart after abort
    run_scan(0, 0, 12, -1);   // start pulse mid-scan, full rate
    run_scan(0, 2, 7, -1);    // start pulse mid-scan, random ready
    for (int i = 0; i < 4; i++) begin
      run_scan(int'($urandom_range(0, 2)), 2, -1, -1);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
